conv_pe_scheduler: RTL and testbench

Sequencer for the 16-PE 3x3 convolution sub-top. It takes a 58x58x16 padded IFM and produces a 56x56x32 OFM in two output-channel passes of 16 PEs each. It generates IFM and weight BRAM read addresses and the PE_en/PE_finish strobes, collects the PE valid vector, and issues OFM write strobes with a linear OFM address. It replaces the hand-timed PE_en/PE_finish pulse train currently driven from the bench.

---
 rtl/conv_pkg.sv | 31 +++
 rtl/conv_addr_gen.sv | 104 ++++++++++
 rtl/conv_pe_scheduler.sv | 98 +++++++++
 tb/tb_conv_pe_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the 16-PE 3x3 convolution scheduler.
package conv_pkg;

  localparam int unsigned IFM_W     = 58;
  localparam int unsigned IFM_H     = 58;
  localparam int unsigned CH        = 16;
  localparam int unsigned K         = 3;
  localparam int unsigned PE_NUM    = 16;
  localparam int unsigned OC_PASSES = 2;
  localparam int unsigned ADDR_W    = 20;

  localparam int unsigned WPC       = CH / 4;  // 32-bit words per IFM pixel
  localparam int unsigned OUT_W     = IFM_W - K + 1;
  localparam int unsigned OUT_H     = IFM_H - K + 1;
  localparam int unsigned BEATS     = K * K * CH / 4;
  localparam int unsigned OFM_PLANE = OUT_W * OUT_W;

  localparam int unsigned CW_W      = $clog2(WPC);
  localparam int unsigned KW        = $clog2(K);
  localparam int unsigned POS_W     = $clog2(OUT_W);
  localparam int unsigned PASS_W    = (OC_PASSES > 1) ? $clog2(OC_PASSES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    FLUSH,
    WAIT_V,
    DONE
  } state_e;

endpackage

// File: rtl/conv_addr_gen.sv
// Beat (ky/kx/cw) and window (col/row/pass) counters with IFM, weight and OFM
// address arithmetic derived from the registered counters.
module conv_addr_gen import conv_pkg::*; #(
  parameter int unsigned ROWS = OUT_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_beat,
  input  logic              step_window,
  output logic              first_beat,
  output logic              last_beat,
  output logic              last_window,
  output logic [ADDR_W-1:0] addr_ifm,
  output logic [ADDR_W-1:0] addr_w,
  output logic [ADDR_W-1:0] ofm_addr
);

  localparam int unsigned PLANE = ROWS * OUT_W;

  logic [CW_W-1:0]   cw_q, cw_d;
  logic [KW-1:0]     kx_q, kx_d;
  logic [KW-1:0]     ky_q, ky_d;
  logic [POS_W-1:0]  col_q, col_d;
  logic [POS_W-1:0]  row_q, row_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              last_cw, last_kx, last_ky;
  logic              last_col, last_row, last_pass;

  always_ff @(posedge clk) begin
    if (reset) begin
      cw_q   <= '0;
      kx_q   <= '0;
      ky_q   <= '0;
      col_q  <= '0;
      row_q  <= '0;
      pass_q <= '0;
    end else begin
      cw_q   <= cw_d;
      kx_q   <= kx_d;
      ky_q   <= ky_d;
      col_q  <= col_d;
      row_q  <= row_d;
      pass_q <= pass_d;
    end
  end

  always_comb begin
    last_cw     = (cw_q == CW_W'(WPC - 1));
    last_kx     = (kx_q == KW'(K - 1));
    last_ky     = (ky_q == KW'(K - 1));
    last_col    = (col_q == POS_W'(OUT_W - 1));
    last_row    = (row_q == POS_W'(ROWS - 1));
    last_pass   = (pass_q == PASS_W'(OC_PASSES - 1));
    first_beat  = (cw_q == '0) && (kx_q == '0) && (ky_q == '0);
    last_beat   = last_cw && last_kx && last_ky;
    last_window = last_col && last_row && last_pass;
  end

  // Beat nest: cw fastest, then kx, then ky; wraps to zero after the last beat.
  always_comb begin
    cw_d = cw_q;
    kx_d = kx_q;
    ky_d = ky_q;
    if (step_beat) begin
      cw_d = last_cw ? '0 : cw_q + CW_W'(1);
      if (last_cw) begin
        kx_d = last_kx ? '0 : kx_q + KW'(1);
        if (last_kx) begin
          ky_d = last_ky ? '0 : ky_q + KW'(1);
        end
      end
    end
  end

  // Window nest: col fastest, then row, then pass; wraps to zero after the last window.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    pass_d = pass_q;
    if (step_window) begin
      col_d = last_col ? '0 : col_q + POS_W'(1);
      if (last_col) begin
        row_d = last_row ? '0 : row_q + POS_W'(1);
        if (last_row) begin
          pass_d = last_pass ? '0 : pass_q + PASS_W'(1);
        end
      end
    end
  end

  always_comb begin
    addr_ifm = ((ADDR_W'(row_q) + ADDR_W'(ky_q)) * ADDR_W'(IFM_W)
                + ADDR_W'(col_q) + ADDR_W'(kx_q)) * ADDR_W'(WPC)
               + ADDR_W'(cw_q);
    addr_w   = ADDR_W'(pass_q) * ADDR_W'(BEATS)
               + ADDR_W'(ky_q) * ADDR_W'(K * WPC)
               + ADDR_W'(kx_q) * ADDR_W'(WPC)
               + ADDR_W'(cw_q);
    ofm_addr = ADDR_W'(pass_q) * ADDR_W'(PLANE)
               + ADDR_W'(row_q) * ADDR_W'(OUT_W)
               + ADDR_W'(col_q);
  end

endmodule

// File: rtl/conv_pe_scheduler.sv
// Window sequencer for the 16-PE convolution sub-top: streams 36 IFM/weight
// beats per window, strobes the PEs, and writes one OFM pixel per window.
module conv_pe_scheduler import conv_pkg::*; #(
  parameter int unsigned OUT_ROWS = OUT_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cal_start,
  input  logic              ofm_ready,
  input  logic [PE_NUM-1:0] valid,
  output logic [ADDR_W-1:0] addr_ifm,
  output logic [ADDR_W-1:0] addr_w,
  output logic              rd_en,
  output logic [PE_NUM-1:0] PE_en,
  output logic [PE_NUM-1:0] PE_finish,
  output logic              ofm_wr_en,
  output logic [ADDR_W-1:0] ofm_addr,
  output logic              busy,
  output logic              done
);

  state_e state_q, state_d;
  logic   pe_en_q, pe_en_d;
  logic   step_beat, step_window;
  logic   first_beat, last_beat, last_window;

  conv_addr_gen #(
    .ROWS (OUT_ROWS)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .step_beat   (step_beat),
    .step_window (step_window),
    .first_beat  (first_beat),
    .last_beat   (last_beat),
    .last_window (last_window),
    .addr_ifm    (addr_ifm),
    .addr_w      (addr_w),
    .ofm_addr    (ofm_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pe_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pe_en_q <= pe_en_d;
    end
  end

  // PE_en lands one cycle after beat 0 so it coincides with the first data word.
  always_comb begin
    state_d     = state_q;
    pe_en_d     = 1'b0;
    step_beat   = 1'b0;
    step_window = 1'b0;
    rd_en       = 1'b0;
    PE_finish   = '0;
    ofm_wr_en   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cal_start) state_d = STREAM;
      end
      STREAM: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        step_beat = 1'b1;
        pe_en_d   = first_beat;
        if (last_beat) state_d = FLUSH;
      end
      FLUSH: begin
        busy    = 1'b1;
        state_d = WAIT_V;
      end
      WAIT_V: begin
        busy = 1'b1;
        if ((&valid) && ofm_ready) begin
          ofm_wr_en   = 1'b1;
          step_window = 1'b1;
          state_d     = last_window ? DONE : STREAM;
        end else begin
          PE_finish = '1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign PE_en = {PE_NUM{pe_en_q}};

endmodule

// File: tb/tb_conv_pe_scheduler.sv
// Directed checks of the convolution scheduler: address streams, strobes,
// backpressure, partial valid, ignored restart, full run and mid-run reset.
module tb_conv_pe_scheduler;

  localparam int unsigned TB_ROWS  = 2;   // two output rows keep the full run short
  localparam int unsigned TB_COLS  = 56;
  localparam int unsigned TB_WINS  = 2 * TB_ROWS * TB_COLS;
  localparam int unsigned TB_PLANE = TB_ROWS * TB_COLS;
  localparam logic [31:0] ALL      = 32'h0000_FFFF;

  logic        clk;
  logic        reset;
  logic        cal_start;
  logic        ofm_ready;
  logic [15:0] valid;
  logic [19:0] addr_ifm;
  logic [19:0] addr_w;
  logic        rd_en;
  logic [15:0] PE_en;
  logic [15:0] PE_finish;
  logic        ofm_wr_en;
  logic [19:0] ofm_addr;
  logic        busy;
  logic        done;

  int n_vec;
  int n_err;
  int cyc;
  int wr_cnt;
  int exp_wr;
  int last_wr_cyc;
  int done_cnt;
  int pe_en_cnt;
  int s0_cyc;
  int snap;

  conv_pe_scheduler #(
    .OUT_ROWS (TB_ROWS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cal_start (cal_start),
    .ofm_ready (ofm_ready),
    .valid     (valid),
    .addr_ifm  (addr_ifm),
    .addr_w    (addr_w),
    .rd_en     (rd_en),
    .PE_en     (PE_en),
    .PE_finish (PE_finish),
    .ofm_wr_en (ofm_wr_en),
    .ofm_addr  (ofm_addr),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples mid-cycle, then advances to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    if (ofm_wr_en === 1'b1) begin
      wr_cnt++;
      chk("wr_addr_seq", 32'(ofm_addr), 32'(exp_wr));
      exp_wr++;
      last_wr_cyc = cyc;
    end
    if (done === 1'b1) done_cnt++;
    if (PE_en[0] === 1'b1) pe_en_cnt++;
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"},     32'(rd_en),     0);
    chk({tag, "_pe_en"},     32'(PE_en),     0);
    chk({tag, "_pe_finish"}, 32'(PE_finish), 0);
    chk({tag, "_wr_en"},     32'(ofm_wr_en), 0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_done"},      32'(done),      0);
    chk({tag, "_addr_ifm"},  32'(addr_ifm),  0);
    chk({tag, "_addr_w"},    32'(addr_w),    0);
    chk({tag, "_ofm_addr"},  32'(ofm_addr),  0);
  endtask

  initial begin
    logic [31:0] e;
    n_vec = 0; n_err = 0; cyc = 0; wr_cnt = 0; exp_wr = 0;
    last_wr_cyc = 0; done_cnt = 0; pe_en_cnt = 0; s0_cyc = 0; snap = 0;
    reset = 1'b1; cal_start = 1'b0; ofm_ready = 1'b1; valid = 16'hFFFF;

    // Reset state
    step(); step();
    reset = 1'b0;
    step();
    chk_all_zero("reset");

    // First window, beat by beat
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    s0_cyc = cyc;
    chk("w0_busy", 32'(busy), 1);
    for (int b = 0; b < 36; b++) begin
      e = 32'((b / 12) * 232 + ((b / 4) % 3) * 4 + (b % 4));
      chk("w0_addr_ifm", 32'(addr_ifm), e);
      chk("w0_addr_w",   32'(addr_w),   32'(b));
      chk("w0_rd_en",    32'(rd_en),    1);
      e = (b == 1) ? ALL : 32'h0;
      chk("w0_pe_en",    32'(PE_en),    e);
      if (b == 4)  chk("w0_b4_ifm",  32'(addr_ifm), 4);
      if (b == 12) chk("w0_b12_ifm", 32'(addr_ifm), 232);
      if (b == 13) chk("w0_b13_ifm", 32'(addr_ifm), 233);
      step();
    end
    chk("flush_rd_en",     32'(rd_en),     0);
    chk("flush_pe_en",     32'(PE_en),     0);
    chk("flush_pe_finish", 32'(PE_finish), 0);
    chk("flush_wr_en",     32'(ofm_wr_en), 0);
    chk("flush_busy",      32'(busy),      1);
    step();
    chk("w0_wr_en",        32'(ofm_wr_en), 1);
    chk("w0_ofm_addr",     32'(ofm_addr),  0);
    chk("w0_pe_finish",    32'(PE_finish), 0);
    chk("w0_rd_en_waitv",  32'(rd_en),     0);
    chk("w0_wr_latency",   32'(cyc - s0_cyc), 37);
    step();
    chk("w1_addr_ifm",  32'(addr_ifm), 4);
    chk("w1_ofm_addr",  32'(ofm_addr), 1);
    chk("w0_pe_en_cnt", 32'(pe_en_cnt), 1);

    // Run to the first window of output row 1
    for (int i = 0; i < 60 * 38 && wr_cnt < 56; i++) step();
    chk("reach_w56",     32'(wr_cnt),   56);
    chk("w56_addr_ifm",  32'(addr_ifm), 232);
    chk("w56_ofm_addr",  32'(ofm_addr), 56);
    chk("w56_addr_w",    32'(addr_w),   0);

    // Backpressure: ofm_ready low for 20 cycles in WAIT_V
    ofm_ready = 1'b0;
    for (int i = 0; i < 100 && PE_finish !== 16'hFFFF; i++) step();
    chk("bp_reach_waitv", 32'(PE_finish), ALL);
    for (int i = 0; i < 20; i++) begin
      chk("bp_pe_finish", 32'(PE_finish), ALL);
      chk("bp_no_wr",     32'(ofm_wr_en), 0);
      step();
    end
    ofm_ready = 1'b1;
    #1;
    chk("bp_wr_en",     32'(ofm_wr_en), 1);
    chk("bp_ofm_addr",  32'(ofm_addr),  56);
    chk("bp_pe_finish_drop", 32'(PE_finish), 0);
    step();

    // Partial valid for 10 cycles
    valid = 16'h7FFF;
    for (int i = 0; i < 100 && PE_finish !== 16'hFFFF; i++) step();
    chk("pv_reach_waitv", 32'(PE_finish), ALL);
    for (int i = 0; i < 10; i++) begin
      chk("pv_pe_finish", 32'(PE_finish), ALL);
      chk("pv_no_wr",     32'(ofm_wr_en), 0);
      step();
    end
    valid = 16'hFFFF;
    #1;
    chk("pv_wr_en",    32'(ofm_wr_en), 1);
    chk("pv_ofm_addr", 32'(ofm_addr),  57);
    step();

    // cal_start while busy is ignored
    for (int i = 0; i < 5; i++) step();
    chk("rs_addr_w_b5", 32'(addr_w), 5);
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    chk("rs_addr_w_b6", 32'(addr_w), 6);
    chk("rs_busy",      32'(busy),   1);
    chk("rs_rd_en",     32'(rd_en),  1);
    for (int i = 0; i < 100 && wr_cnt < 59; i++) step();
    chk("rs_wr_cnt",      32'(wr_cnt),   59);
    chk("w59_addr_ifm",   32'(addr_ifm), 244);
    chk("w59_ofm_addr",   32'(ofm_addr), 59);

    // Pass boundary: first pass-1 window
    for (int i = 0; i < 60 * 38 && wr_cnt < int'(TB_PLANE); i++) step();
    chk("reach_pass1",    32'(wr_cnt),   32'(TB_PLANE));
    chk("p1_ofm_addr",    32'(ofm_addr), 32'(TB_PLANE));
    chk("p1_addr_ifm",    32'(addr_ifm), 0);
    for (int b = 0; b < 36; b++) begin
      chk("p1_addr_w", 32'(addr_w), 32'(36 + b));
      step();
    end

    // Completion
    for (int i = 0; i < 120 * 38 && done !== 1'b1; i++) step();
    chk("done_seen",      32'(done),   1);
    chk("done_busy",      32'(busy),   0);
    chk("full_wr_cnt",    32'(wr_cnt), 32'(TB_WINS));
    chk("last_wr_addr",   32'(exp_wr), 32'(TB_WINS));
    chk("done_latency",   32'(cyc - last_wr_cyc), 1);
    step();
    chk("idle_done",      32'(done),     0);
    chk("idle_busy",      32'(busy),     0);
    chk("done_cnt",       32'(done_cnt), 1);
    chk("idle_ofm_addr",  32'(ofm_addr), 0);

    // Reset in the middle of STREAM at beat 17
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("ab_addr_w_b17",   32'(addr_w),   17);
    chk("ab_addr_ifm_b17", 32'(addr_ifm), 237);
    reset = 1'b1;
    step();
    chk_all_zero("abort");
    reset = 1'b0;
    exp_wr = 0;
    snap = wr_cnt;
    step();
    chk("ab_idle_busy", 32'(busy), 0);
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    chk("re_addr_ifm", 32'(addr_ifm), 0);
    chk("re_ofm_addr", 32'(ofm_addr), 0);
    chk("re_rd_en",    32'(rd_en),    1);
    chk("re_busy",     32'(busy),     1);
    for (int i = 0; i < 60 && wr_cnt < snap + 1; i++) step();
    chk("re_wr_cnt",   32'(wr_cnt),   32'(snap + 1));
    chk("re_done_cnt", 32'(done_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
